// File: rtl/hpgp_turbo_itl_rx.sv
// Receive-side HPGP turbo interleaver buffer: captures one PB of 2-bit symbols and replays it in
// natural and interleaved order at the same time. Define ITL_PAIR_SWAP_EN to enable the odd-position pair swap.
module hpgp_turbo_itl_rx #(
  parameter int MAX_L = 2080,
  parameter int AW    = 12
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic [1:0] din,
  input  logic       din_vld,
  output logic [1:0] rdata,
  output logic [1:0] rdata_itl,
  output logic       dout_vld
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   itl_q, itl_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   st_q, st_d;
  logic [AW-1:0]   of_q, of_d;
  logic [AW-1:0]   sel_len, sel_st, sel_of;
  logic [AW:0]     itl_sum, itl_wrap;
  logic [AW-1:0]   itl_next;
  logic            wr_en, rd_en;

  logic [1:0]      mem [MAX_L];
  logic [1:0]      ram_a_q, ram_b_q;
  logic [1:0]      itl_sym;
  logic            vld1_q;
  logic [1:0]      rdata_q, rdata_itl_q;
  logic            dout_vld_q;

  always_comb begin
    sel_len = AW'(64);
    sel_st  = AW'(17);
    sel_of  = AW'(5);
    case (pb_size)
      2'd1: begin
        sel_len = AW'(544);
        sel_st  = AW'(33);
        sel_of  = AW'(7);
      end
      2'd2: begin
        sel_len = AW'(2080);
        sel_st  = AW'(51);
        sel_of  = AW'(11);
      end
      default: ;
    endcase
  end

  // ST is always smaller than L, so a single conditional subtract is a complete mod-L reduction.
  always_comb begin
    itl_sum  = {1'b0, itl_q} + {1'b0, st_q};
    itl_wrap = itl_sum - {1'b0, len_q};
    itl_next = (itl_sum >= {1'b0, len_q}) ? itl_wrap[AW-1:0] : itl_sum[AW-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    itl_d   = itl_q;
    len_d   = len_q;
    st_d    = st_q;
    of_d    = of_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_vld) begin
          len_d   = sel_len;
          st_d    = sel_st;
          of_d    = sel_of;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == len_q - AW'(1)) begin
          cnt_d   = '0;
          itl_d   = of_q;
          state_d = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        cnt_d = cnt_q + AW'(1);
        itl_d = itl_next;
        if (cnt_q == len_q - AW'(1)) begin
          cnt_d   = '0;
          itl_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      itl_q   <= '0;
      len_q   <= '0;
      st_q    <= '0;
      of_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      itl_q   <= itl_d;
      len_q   <= len_d;
      st_q    <= st_d;
      of_q    <= of_d;
    end
  end

  // Symbol RAM with one write port and two synchronous read ports; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q] <= din;
    if (rd_en) begin
      ram_a_q <= mem[cnt_q];
      ram_b_q <= mem[itl_q];
    end
  end

`ifdef ITL_PAIR_SWAP_EN
  logic odd1_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) odd1_q <= 1'b0;
    else if (rd_en) odd1_q <= itl_q[0];
  end

  assign itl_sym = odd1_q ? {ram_b_q[0], ram_b_q[1]} : ram_b_q;
`else
  assign itl_sym = ram_b_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld1_q      <= 1'b0;
      rdata_q     <= '0;
      rdata_itl_q <= '0;
      dout_vld_q  <= 1'b0;
    end else begin
      vld1_q     <= rd_en;
      dout_vld_q <= vld1_q;
      if (vld1_q) begin
        rdata_q     <= ram_a_q;
        rdata_itl_q <= itl_sym;
      end
    end
  end

  assign rdata     = rdata_q;
  assign rdata_itl = rdata_itl_q;
  assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_hpgp_turbo_itl_rx.sv
// Self-checking bench for hpgp_turbo_itl_rx: table-driven blocks checked cycle by cycle against a
// plain-arithmetic interleaver model, plus hand-written reset and idle sequences.
`timescale 1ps/1ps
module tb_hpgp_turbo_itl_rx;

  logic       clk;
  logic       n_rst;
  logic [1:0] pb_size;
  logic [1:0] din;
  logic       din_vld;
  logic [1:0] rdata;
  logic [1:0] rdata_itl;
  logic       dout_vld;

  int vectors;
  int miscompares;

  logic [1:0] refMem [2080];

  typedef struct {
    logic [1:0] pbSize;
    int         pattern;
    int         expLen;
    int         expK1;
    int         extraStrobe;
  } vec_t;

  hpgp_turbo_itl_rx dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pb_size   (pb_size),
    .din       (din),
    .din_vld   (din_vld),
    .rdata     (rdata),
    .rdata_itl (rdata_itl),
    .dout_vld  (dout_vld)
  );

  always #5 clk = ~clk;

  function automatic int modelLen(input logic [1:0] s);
    case (s)
      2'd1:    return 544;
      2'd2:    return 2080;
      default: return 64;
    endcase
  endfunction

  function automatic int modelSt(input logic [1:0] s);
    case (s)
      2'd1:    return 33;
      2'd2:    return 51;
      default: return 17;
    endcase
  endfunction

  function automatic int modelOf(input logic [1:0] s);
    case (s)
      2'd1:    return 7;
      2'd2:    return 11;
      default: return 5;
    endcase
  endfunction

  function automatic logic [1:0] refItl(input logic [1:0] s, input int k);
    int idx;
    logic [1:0] v;
    idx = (modelOf(s) + modelSt(s) * k) % modelLen(s);
    v = refMem[idx];
`ifdef ITL_PAIR_SWAP_EN
    if (idx % 2 == 1) v = {v[0], v[1]};
`endif
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fillData(input logic [1:0] s, input int pattern);
    int len;
    len = modelLen(s);
    for (int i = 0; i < len; i++) begin
      case (pattern)
        0:       refMem[i] = (i < 48) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : ((i % 2 == 0) ? 2'b00 : 2'b11);
        1:       refMem[i] = 2'(i % 4);
        default: refMem[i] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  // Drives the strobe and the L symbols; returns just after the edge that captures the last symbol.
  task automatic applyStimulus(input logic [1:0] s, input int pattern, input int extraStrobe);
    int len;
    len = modelLen(s);
    fillData(s, pattern);
    @(negedge clk);
    pb_size = s;
    din_vld = 1'b1;
    din     = 2'($urandom_range(0, 3));
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      din_vld = (i == extraStrobe);
      pb_size = 2'($urandom_range(0, 3));
      din     = refMem[i];
    end
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  // Walks the replay window one cycle at a time, starting right after the last-capture edge.
  task automatic checkOutput(input vec_t v);
    int highCount;
    int k;
    bit expV;
    highCount = 0;
    for (int j = 1; j <= v.expLen + 2; j++) begin
      @(posedge clk);
      #1;
      k = j - 2;
      expV = (k >= 0) && (k < v.expLen);
      checkVal("dout_vld", 32'(dout_vld), 32'(expV));
      if (dout_vld) highCount++;
      if (expV) begin
        checkVal("rdata", 32'(rdata), 32'(refMem[k]));
        checkVal("rdata_itl", 32'(rdata_itl), 32'(refItl(v.pbSize, k)));
        if (k == 1 && v.expK1 >= 0) checkVal("itl_k1", 32'(rdata_itl), 32'(v.expK1));
        if (v.pattern == 0 && v.pbSize == 2'd0) begin
`ifdef ITL_PAIR_SWAP_EN
          if (k == 0) checkVal("pb16_swap_k0", 32'(rdata_itl), 32'h1);
`else
          if (k == 0) checkVal("pb16_itl_k0", 32'(rdata_itl), 32'h2);
`endif
          if (k == 1)  checkVal("pb16_itl_k1", 32'(rdata_itl), 32'h1);
          if (k == 3)  checkVal("pb16_itl_k3", 32'(rdata_itl), 32'h0);
          if (k == 63) checkVal("pb16_itl_k63", 32'(rdata_itl), 32'h0);
        end
      end
      if (j == v.expLen + 2) checkVal("rdata_hold", 32'(rdata), 32'(refMem[v.expLen - 1]));
    end
    checkVal("block_len", 32'(highCount), 32'(v.expLen));
  endtask

  vec_t table_q [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk     = 1'b0;
    n_rst   = 1'b0;
    pb_size = 2'd0;
    din     = 2'd0;
    din_vld = 1'b0;

    table_q[0] = '{pbSize: 2'd0, pattern: 0, expLen: 64,   expK1: -1, extraStrobe: -1};
    table_q[1] = '{pbSize: 2'd1, pattern: 1, expLen: 544,  expK1: 0,  extraStrobe: -1};
    table_q[2] = '{pbSize: 2'd2, pattern: 1, expLen: 2080, expK1: 2,  extraStrobe: -1};
    table_q[3] = '{pbSize: 2'd3, pattern: 2, expLen: 64,   expK1: -1, extraStrobe: -1};
    table_q[4] = '{pbSize: 2'd0, pattern: 2, expLen: 64,   expK1: -1, extraStrobe: 20};
    table_q[5] = '{pbSize: 2'd1, pattern: 2, expLen: 544,  expK1: -1, extraStrobe: 100};

    #3;
    checkVal("reset_dout_vld", 32'(dout_vld), 32'h0);
    checkVal("reset_rdata", 32'(rdata), 32'h0);
    checkVal("reset_rdata_itl", 32'(rdata_itl), 32'h0);
    #4;
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      din = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      checkVal("idle_dout_vld", 32'(dout_vld), 32'h0);
      checkVal("idle_rdata", 32'(rdata), 32'h0);
    end

    for (int t = 0; t < 6; t++) begin
      applyStimulus(table_q[t].pbSize, table_q[t].pattern, table_q[t].extraStrobe);
      checkOutput(table_q[t]);
    end

    applyStimulus(2'd0, 2, -1);
    for (int i = 0; i < 12; i++) @(posedge clk);
    #1;
    checkVal("pre_reset_vld", 32'(dout_vld), 32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    checkVal("midread_reset_vld", 32'(dout_vld), 32'h0);
    checkVal("midread_reset_rdata", 32'(rdata), 32'h0);
    checkVal("midread_reset_itl", 32'(rdata_itl), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkVal("post_reset_idle", 32'(dout_vld), 32'h0);
    end

    applyStimulus(2'd0, 0, -1);
    checkOutput(table_q[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
